// File: rtl/multi_stage_database_loader_pkg.sv
// Shared sizing helpers and FSM encoding for the multi-stage Haar parameter loader.
package embedded_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2,
    ST_BOOT = 2'd3
  } load_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < $unsigned(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic int slot_depth(input int n_cls, input int n_par, input int n_thr);
    return n_cls * n_par + n_thr;
  endfunction

  function automatic int stage_width(input int n_stages);
    if (n_stages > 1) begin
      return clog2(n_stages);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/multi_stage_database_loader_if.sv
// Request/swap handshake and active-bank view between the cascade engine and the stage loader.
interface multi_stage_database_loader_if #(
  parameter int STAGE_W    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_DEPTH = embedded_stage_pkg::slot_depth(10, 19, 3)
);
  logic                             i_load_req;
  logic [STAGE_W-1:0]               i_load_stage;
  logic                             i_swap;
  logic                             o_load_busy;
  logic                             o_load_done;
  logic                             o_load_err;
  logic                             o_ready;
  logic [STAGE_W-1:0]               o_active_stage;
  logic [DATA_WIDTH*SLOT_DEPTH-1:0] o_rom;

  modport master (
    output i_load_req, i_load_stage, i_swap,
    input  o_load_busy, o_load_done, o_load_err, o_ready, o_active_stage, o_rom
  );

  modport slave (
    input  i_load_req, i_load_stage, i_swap,
    output o_load_busy, o_load_done, o_load_err, o_ready, o_active_stage, o_rom
  );
endinterface

// File: rtl/multi_stage_database_loader_rom.sv
// Synchronous stage-parameter ROM with a registered read port (one cycle of latency).
// The stage image is compiled in: word a holds a+1; an empty INIT_FILE yields a blank ROM.
module stage_param_rom #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 16,
  parameter string INIT_FILE  = "memory.mif"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam bit BLANK_IMAGE = (INIT_FILE == "");

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Image lookup for the presented address.
  always_comb begin
    data_d = '0;
    if (BLANK_IMAGE) begin
      data_d = '0;
    end else begin
      data_d = DATA_WIDTH'(addr_i) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
endmodule

// File: rtl/multi_stage_database_loader.sv
// Copies one cascade stage from the stage ROM into the shadow half of a ping-pong register file;
// the evaluation engine reads the active half until it asks for a swap.
module multi_stage_database_loader
  import embedded_stage_pkg::*;
#(
  parameter int    ADDR_WIDTH               = 12,
  parameter int    DATA_WIDTH               = 16,
  parameter int    NUM_STAGES               = 4,
  parameter int    NUM_CLASSIFIERS          = 10,
  parameter int    NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int    NUM_STAGE_THRESHOLD      = 3,
  parameter int    AUTO_LOAD_STAGE0         = 1,
  parameter string FILE_STAGE_MEM           = "memory.mif"
) (
  input  logic                          clk_fpga,
  input  logic                          reset_fpga,
  multi_stage_database_loader_if.slave  bus
);
  localparam int SLOT_DEPTH = slot_depth(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER, NUM_STAGE_THRESHOLD);
  localparam int SW         = stage_width(NUM_STAGES);
  localparam int CW         = clog2(SLOT_DEPTH + 1);
  localparam int IW         = (SLOT_DEPTH > 1) ? clog2(SLOT_DEPTH) : 1;

  localparam logic [CW-1:0]  CNT_END     = CW'(SLOT_DEPTH);
  localparam logic [IW-1:0]  LAST_IDX    = IW'(SLOT_DEPTH - 1);
  localparam load_state_e    RESET_STATE = (AUTO_LOAD_STAGE0 != 0) ? ST_BOOT : ST_IDLE;

  load_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d;
  logic                  shadow_valid_q, shadow_valid_d;
  logic [SW-1:0]         shadow_stage_q, shadow_stage_d;
  logic                  boot_q, boot_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic [SW-1:0]         active_stage_q, active_stage_d;

  logic [DATA_WIDTH-1:0] bank0_q [SLOT_DEPTH];
  logic [DATA_WIDTH-1:0] bank1_q [SLOT_DEPTH];

  logic [ADDR_WIDTH-1:0]            rom_addr_s;
  logic [DATA_WIDTH-1:0]            rom_data_s;
  logic                             stage_ok_s;
  logic [DATA_WIDTH*SLOT_DEPTH-1:0] rom_flat_s;

  assign stage_ok_s = (32'(bus.i_load_stage) < 32'(NUM_STAGES));
  assign rom_addr_s = base_q + ADDR_WIDTH'(rd_cnt_q);

  stage_param_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_FILE  (FILE_STAGE_MEM)
  ) u_rom (
    .clk    (clk_fpga),
    .rst    (reset_fpga),
    .addr_i (rom_addr_s),
    .data_o (rom_data_s)
  );

  // Next-state, counter and output decode for the load sequencer.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    rd_cnt_d       = rd_cnt_q;
    wr_pend_d      = 1'b0;
    wr_idx_d       = wr_idx_q;
    shadow_valid_d = shadow_valid_q;
    shadow_stage_d = shadow_stage_q;
    boot_d         = boot_q;
    bank_sel_d     = bank_sel_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    ready_d        = ready_q;
    active_stage_d = active_stage_q;

    case (state_q)
      ST_BOOT: begin
        base_d         = '0;
        rd_cnt_d       = '0;
        shadow_valid_d = 1'b0;
        shadow_stage_d = '0;
        busy_d         = 1'b1;
        boot_d         = 1'b1;
        state_d        = ST_FILL;
      end
      ST_IDLE: begin
        // Swap is evaluated first so a same-cycle load targets the freshly vacated bank.
        if (bus.i_swap && shadow_valid_q) begin
          bank_sel_d     = ~bank_sel_q;
          active_stage_d = shadow_stage_q;
          ready_d        = 1'b1;
          shadow_valid_d = 1'b0;
        end else begin
          bank_sel_d     = bank_sel_q;
        end
        if (bus.i_load_req && stage_ok_s) begin
          base_d         = ADDR_WIDTH'(32'(bus.i_load_stage) * 32'(SLOT_DEPTH));
          rd_cnt_d       = '0;
          shadow_valid_d = 1'b0;
          shadow_stage_d = bus.i_load_stage;
          busy_d         = 1'b1;
          state_d        = ST_FILL;
        end else if (bus.i_load_req) begin
          err_d          = 1'b1;
        end else begin
          err_d          = 1'b0;
        end
      end
      ST_FILL: begin
        if (rd_cnt_q < CNT_END) begin
          wr_pend_d = 1'b1;
          wr_idx_d  = IW'(rd_cnt_q);
          rd_cnt_d  = rd_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          wr_pend_d = 1'b0;
        end
        if (wr_pend_q && (wr_idx_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (boot_q) begin
          bank_sel_d     = ~bank_sel_q;
          active_stage_d = shadow_stage_q;
          ready_d        = 1'b1;
          shadow_valid_d = 1'b0;
          boot_d         = 1'b0;
        end else begin
          shadow_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q        <= RESET_STATE;
      base_q         <= '0;
      rd_cnt_q       <= '0;
      wr_pend_q      <= 1'b0;
      wr_idx_q       <= '0;
      shadow_valid_q <= 1'b0;
      shadow_stage_q <= '0;
      boot_q         <= 1'b0;
      bank_sel_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ready_q        <= 1'b0;
      active_stage_q <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_pend_q      <= wr_pend_d;
      wr_idx_q       <= wr_idx_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_stage_q <= shadow_stage_d;
      boot_q         <= boot_d;
      bank_sel_q     <= bank_sel_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      ready_q        <= ready_d;
      active_stage_q <= active_stage_d;
    end
  end

  // Shadow-bank write; bank contents carry no reset and the active bank is never written.
  always_ff @(posedge clk_fpga) begin
    if (wr_pend_q) begin
      if (bank_sel_q) begin
        bank0_q[wr_idx_q] <= rom_data_s;
      end else begin
        bank1_q[wr_idx_q] <= rom_data_s;
      end
    end
  end

  // Active-bank view flattened for the evaluation engine.
  always_comb begin
    rom_flat_s = '0;
    for (int k = 0; k < SLOT_DEPTH; k++) begin
      rom_flat_s[k*DATA_WIDTH +: DATA_WIDTH] = bank_sel_q ? bank1_q[k] : bank0_q[k];
    end
  end

  assign bus.o_load_busy    = busy_q;
  assign bus.o_load_done    = done_q;
  assign bus.o_load_err     = err_q;
  assign bus.o_ready        = ready_q;
  assign bus.o_active_stage = active_stage_q;
  assign bus.o_rom          = rom_flat_s;
endmodule

// File: tb/tb_multi_stage_database_loader.sv
// Bench for multi_stage_database_loader: one auto-boot instance, one manual instance, random stage traffic.
module tb_multi_stage_database_loader;
  import embedded_stage_pkg::*;

  localparam int NS  = 3;
  localparam int NC  = 2;
  localparam int NP  = 3;
  localparam int NT  = 1;
  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int SD  = slot_depth(NC, NP, NT);
  localparam int SW  = stage_width(NS);
  localparam int LAT = SD + 2;

  logic clk_fpga = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  int act_m;
  int shs_m;
  bit shv_m;

  always #5 clk_fpga = ~clk_fpga;

  multi_stage_database_loader_if #(.STAGE_W(SW), .DATA_WIDTH(DW), .SLOT_DEPTH(SD)) if_a ();
  multi_stage_database_loader_if #(.STAGE_W(SW), .DATA_WIDTH(DW), .SLOT_DEPTH(SD)) if_b ();

  multi_stage_database_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STAGES(NS), .NUM_CLASSIFIERS(NC),
    .NUM_PARAM_PER_CLASSIFIER(NP), .NUM_STAGE_THRESHOLD(NT), .AUTO_LOAD_STAGE0(1),
    .FILE_STAGE_MEM("memory.mif")
  ) dut_a (.clk_fpga(clk_fpga), .reset_fpga(rst_a), .bus(if_a));

  multi_stage_database_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STAGES(NS), .NUM_CLASSIFIERS(NC),
    .NUM_PARAM_PER_CLASSIFIER(NP), .NUM_STAGE_THRESHOLD(NT), .AUTO_LOAD_STAGE0(0),
    .FILE_STAGE_MEM("memory.mif")
  ) dut_b (.clk_fpga(clk_fpga), .reset_fpga(rst_b), .bus(if_b));

  // ROM word a = a+1 and stage s starts at s*SD, so word k of stage s is s*SD+k+1.
  function automatic logic [SD*DW-1:0] stage_image(input int stage);
    logic [SD*DW-1:0] img;
    img = '0;
    for (int k = 0; k < SD; k++) img[k*DW +: DW] = DW'(stage * SD + k + 1);
    return img;
  endfunction

  task automatic step();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic a_request(input int stage, output int accept_wait);
    if_a.i_load_req   = 1'b1;
    if_a.i_load_stage = SW'(stage);
    accept_wait = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_a.o_load_busy) begin
        accept_wait = i;
        break;
      end
    end
    if_a.i_load_req = 1'b0;
  endtask

  task automatic a_wait_done(output int lat, output int rom_moves);
    logic [SD*DW-1:0] snap;
    snap = if_a.o_rom;
    lat = -1;
    rom_moves = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (if_a.o_rom !== snap) rom_moves++;
      if (if_a.o_load_done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic a_swap();
    if_a.i_swap = 1'b1;
    step();
    if_a.i_swap = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.i_load_req = 1'b0; if_a.i_load_stage = '0; if_a.i_swap = 1'b0;
    if_b.i_load_req = 1'b0; if_b.i_load_stage = '0; if_b.i_swap = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({if_a.o_load_busy, if_a.o_load_done, if_a.o_load_err, if_a.o_ready, if_a.o_active_stage} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got busy/done/err/ready=%b%b%b%b stage=%0d, expected all 0",
               if_a.o_load_busy, if_a.o_load_done, if_a.o_load_err, if_a.o_ready, if_a.o_active_stage);
    end
    n_cmp++;
    if ({if_b.o_load_busy, if_b.o_load_done, if_b.o_load_err, if_b.o_ready, if_b.o_active_stage} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got busy/done/err/ready=%b%b%b%b stage=%0d, expected all 0",
               if_b.o_load_busy, if_b.o_load_done, if_b.o_load_err, if_b.o_ready, if_b.o_active_stage);
    end
  endtask

  task automatic test_auto_boot();
    rst_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i < 10) begin
        n_cmp++;
        if ({if_a.o_load_busy, if_a.o_load_done, if_a.o_ready} !== 3'b100) begin
          n_bad++;
          $display("FAIL boot_progress cycle %0d: got busy/done/ready=%b%b%b, expected 100",
                   i, if_a.o_load_busy, if_a.o_load_done, if_a.o_ready);
        end
      end else begin
        n_cmp++;
        if ({if_a.o_load_done, if_a.o_ready} !== 2'b11) begin
          n_bad++;
          $display("FAIL boot_done cycle %0d: got done/ready=%b%b, expected 11", i, if_a.o_load_done, if_a.o_ready);
        end
      end
    end
    n_cmp++;
    if (if_a.o_rom !== stage_image(0) || if_a.o_active_stage !== SW'(0)) begin
      n_bad++;
      $display("FAIL boot_image: got rom=%h stage=%0d, expected rom=%h stage=0", if_a.o_rom, if_a.o_active_stage, stage_image(0));
    end
    step();
    n_cmp++;
    if ({if_a.o_load_busy, if_a.o_load_done, if_a.o_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL boot_settle: got busy/done/ready=%b%b%b, expected 001", if_a.o_load_busy, if_a.o_load_done, if_a.o_ready);
    end
    act_m = 0; shv_m = 1'b0; shs_m = 0;
  endtask

  task automatic test_load_swap();
    int w, lat, mv;
    a_request(2, w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL load_accept: got wait=%0d, expected 0", w); end
    a_wait_done(lat, mv);
    n_cmp++;
    if (lat != LAT) begin n_bad++; $display("FAIL load_latency: got %0d, expected %0d", lat, LAT); end
    n_cmp++;
    if (mv != 0 || if_a.o_active_stage !== SW'(act_m)) begin
      n_bad++;
      $display("FAIL load_active_kept: got rom changes=%0d stage=%0d, expected 0 and %0d", mv, if_a.o_active_stage, act_m);
    end
    shv_m = 1'b1; shs_m = 2;
    a_swap();
    act_m = 2; shv_m = 1'b0;
    n_cmp++;
    if (if_a.o_rom !== stage_image(2) || if_a.o_active_stage !== SW'(2)) begin
      n_bad++;
      $display("FAIL swap_stage2: got rom=%h stage=%0d, expected rom=%h stage=2", if_a.o_rom, if_a.o_active_stage, stage_image(2));
    end
  endtask

  task automatic test_bad_stage();
    if_a.i_load_req = 1'b1; if_a.i_load_stage = SW'(NS);
    step();
    if_a.i_load_req = 1'b0;
    n_cmp++;
    if ({if_a.o_load_err, if_a.o_load_busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL bad_stage_err: got err/busy=%b%b, expected 10", if_a.o_load_err, if_a.o_load_busy);
    end
    step();
    n_cmp++;
    if ({if_a.o_load_err, if_a.o_load_busy, if_a.o_load_done} !== 3'b000 || if_a.o_rom !== stage_image(act_m)
        || if_a.o_active_stage !== SW'(act_m)) begin
      n_bad++;
      $display("FAIL bad_stage_after: got err/busy/done=%b%b%b stage=%0d, expected 000 stage=%0d",
               if_a.o_load_err, if_a.o_load_busy, if_a.o_load_done, if_a.o_active_stage, act_m);
    end
  endtask

  task automatic test_ignore_during_fill();
    int s1, s2, w, lat, mv;
    logic [SD*DW-1:0] snap;
    s1 = ($urandom_range(0, 1) == 1) ? 2 : 0;
    s2 = (s1 + 1 + int'($urandom_range(0, NS - 2))) % NS;
    a_request(s1, w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL fill_accept: got wait=%0d, expected 0", w); end
    snap = if_a.o_rom; lat = -1; mv = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (if_a.o_rom !== snap) mv++;
      if (if_a.o_load_done) begin
        lat = n;
        break;
      end
      if (n == 3) begin
        if_a.i_load_req = 1'b1; if_a.i_load_stage = SW'(s2); if_a.i_swap = 1'b1;
      end else if (n == 4) begin
        if_a.i_load_req = 1'b0; if_a.i_swap = 1'b0;
      end
    end
    n_cmp++;
    if (lat != LAT) begin n_bad++; $display("FAIL fill_ignore_latency: got %0d, expected %0d", lat, LAT); end
    n_cmp++;
    if (mv != 0) begin n_bad++; $display("FAIL fill_ignore_swap: got %0d rom changes, expected 0", mv); end
    step();
    n_cmp++;
    if ({if_a.o_load_busy, if_a.o_load_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL fill_no_queue: got busy/done=%b%b, expected 00", if_a.o_load_busy, if_a.o_load_done);
    end
    shv_m = 1'b1; shs_m = s1;
  endtask

  task automatic test_swap_and_load();
    int lat, mv;
    if_a.i_swap = 1'b1; if_a.i_load_req = 1'b1; if_a.i_load_stage = SW'(1);
    step();
    if_a.i_swap = 1'b0; if_a.i_load_req = 1'b0;
    act_m = shs_m; shv_m = 1'b0;
    n_cmp++;
    if (if_a.o_rom !== stage_image(act_m) || if_a.o_active_stage !== SW'(act_m) || if_a.o_load_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL swap_load_same_cycle: got rom=%h stage=%0d busy=%b, expected rom=%h stage=%0d busy=1",
               if_a.o_rom, if_a.o_active_stage, if_a.o_load_busy, stage_image(act_m), act_m);
    end
    a_wait_done(lat, mv);
    n_cmp++;
    if (lat != LAT || mv != 0) begin
      n_bad++;
      $display("FAIL swap_load_fill: got latency=%0d rom changes=%0d, expected %0d and 0", lat, mv, LAT);
    end
    a_swap();
    act_m = 1;
    n_cmp++;
    if (if_a.o_rom !== stage_image(1) || if_a.o_active_stage !== SW'(1)) begin
      n_bad++;
      $display("FAIL swap_load_stage1: got rom=%h stage=%0d, expected rom=%h stage=1", if_a.o_rom, if_a.o_active_stage, stage_image(1));
    end
  endtask

  task automatic test_random();
    int stage, w, lat, mv;
    for (int it = 0; it < 8; it++) begin
      stage = int'($urandom_range(0, NS));
      if ($urandom_range(0, 1) == 1) begin
        a_swap();
        if (shv_m) begin
          act_m = shs_m;
          shv_m = 1'b0;
        end
      end
      n_cmp++;
      if (if_a.o_rom !== stage_image(act_m) || if_a.o_active_stage !== SW'(act_m) || if_a.o_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL random_active it %0d: got rom=%h stage=%0d ready=%b, expected rom=%h stage=%0d ready=1",
                 it, if_a.o_rom, if_a.o_active_stage, if_a.o_ready, stage_image(act_m), act_m);
      end
      if (stage >= NS) begin
        if_a.i_load_req = 1'b1; if_a.i_load_stage = SW'(stage);
        step();
        if_a.i_load_req = 1'b0;
        n_cmp++;
        if ({if_a.o_load_err, if_a.o_load_busy} !== 2'b10) begin
          n_bad++;
          $display("FAIL random_err it %0d: got err/busy=%b%b, expected 10", it, if_a.o_load_err, if_a.o_load_busy);
        end
        step();
      end else begin
        a_request(stage, w);
        a_wait_done(lat, mv);
        n_cmp++;
        if (w != 0 || lat != LAT || mv != 0) begin
          n_bad++;
          $display("FAIL random_load it %0d stage %0d: got wait=%0d latency=%0d rom changes=%0d, expected 0/%0d/0",
                   it, stage, w, lat, mv, LAT);
        end
        shv_m = 1'b1; shs_m = stage;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int busy_seen, got;
    rst_b = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if_b.o_load_busy || if_b.o_ready) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0) begin n_bad++; $display("FAIL manual_no_boot: got %0d busy/ready cycles, expected 0", busy_seen); end
    if_b.i_load_req = 1'b1; if_b.i_load_stage = SW'(1);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin step(); if (if_b.o_load_busy) got = 1; end
    if_b.i_load_req = 1'b0;
    for (int i = 0; i < 40 && got == 1; i++) begin step(); if (if_b.o_load_done) got = 2; end
    if_b.i_swap = 1'b1;
    step();
    if_b.i_swap = 1'b0;
    n_cmp++;
    if (got != 2 || if_b.o_rom !== stage_image(1) || if_b.o_ready !== 1'b1 || if_b.o_active_stage !== SW'(1)) begin
      n_bad++;
      $display("FAIL manual_load1: got progress=%0d rom=%h ready=%b stage=%0d, expected 2 rom=%h ready=1 stage=1",
               got, if_b.o_rom, if_b.o_ready, if_b.o_active_stage, stage_image(1));
    end
    if_b.i_load_req = 1'b1; if_b.i_load_stage = SW'(2);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin step(); if (if_b.o_load_busy) got = 1; end
    if_b.i_load_req = 1'b0;
    repeat (4) step();
    rst_b = 1'b1;
    #1;
    n_cmp++;
    if (got != 1 || {if_b.o_load_busy, if_b.o_load_done, if_b.o_load_err, if_b.o_ready, if_b.o_active_stage} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_load: got accept=%0d busy/done/err/ready=%b%b%b%b stage=%0d, expected 1 and all 0",
               got, if_b.o_load_busy, if_b.o_load_done, if_b.o_load_err, if_b.o_ready, if_b.o_active_stage);
    end
    repeat (2) step();
    rst_b = 1'b0;
    step();
    if_b.i_swap = 1'b1;
    step();
    if_b.i_swap = 1'b0;
    n_cmp++;
    if ({if_b.o_ready, if_b.o_active_stage} !== '0) begin
      n_bad++;
      $display("FAIL swap_after_reset: got ready=%b stage=%0d, expected 0 and 0", if_b.o_ready, if_b.o_active_stage);
    end
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (if_b.o_load_busy || if_b.o_load_done || if_b.o_ready) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0) begin n_bad++; $display("FAIL idle_after_reset: got %0d active cycles, expected 0", busy_seen); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_auto_boot();
    test_load_swap();
    test_bad_stage();
    test_ignore_during_fill();
    test_swap_and_load();
    test_random();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
